vdc_32bit: RTL and testbench

VDC_32BIT -- requirements
Module: vdc_32bit

---
 rtl/vdc_32bit.sv | 135 +++++++++++++
 tb/tb_vdc_32bit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_32bit.sv
// vdc_32bit: van der Corput sequence generator, radix BASE, unsigned Q0.32 output.
// Each pop advances a 32-bit count and computes vdc(count+1). The computation
// runs in two phases. First, the digits are peeled off least-significant first
// onto a stack. Then they are folded back most-significant first, dividing by
// BASE at every step. Flooring at each step of that fold is exact: an integer
// added before the next divide cannot change the final floor.
module vdc_32bit #(
  parameter int BASE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pop_enable,
  input  logic [31:0] seed,
  input  logic        reseed_enable,
  output logic [31:0] vdc_out,
  output logic        valid,
  output logic        busy
);

  // Number of base-b digits needed to write 2^32-1; guarded so an illegal
  // radix reaches the elaboration check below instead of looping forever.
  function automatic int calc_digits(input int b);
    longint unsigned v;
    int c;
    if (b < 2) return 1;
    v = 64'hFFFF_FFFF;
    c = 0;
    while (v != 0) begin
      v = v / 64'(b);
      c++;
    end
    return c;
  endfunction

  localparam int MAX_DIGITS = calc_digits(BASE);
  localparam int DW  = (BASE < 2) ? 1 : $clog2(BASE);
  localparam int AW  = 32 + DW;
  localparam int IW  = $clog2(MAX_DIGITS);
  localparam int SPW = $clog2(MAX_DIGITS + 1);
  localparam logic [31:0]   BASE_K = 32'(BASE);
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  if (BASE < 2 || BASE > 64) begin : g_base_check
    $error("vdc_32bit: BASE must lie in 2..64");
  end

  typedef enum logic [1:0] {IDLE, EXTRACT, ACCUM, DONE} state_t;

  state_t         state;
  logic [31:0]    count;
  logic [31:0]    quot;
  logic [31:0]    acc;
  logic [SPW-1:0] sp;
  logic [DW-1:0]  stack [MAX_DIGITS];

  logic [31:0]    next_count;
  logic [31:0]    next_quot;
  logic [DW-1:0]  low_digit;
  logic [DW-1:0]  top_digit;
  logic [AW-1:0]  acc_sum;
  logic [AW-1:0]  acc_div;

  // Datapath: next count, digit split of the quotient, and one fold step.
  // acc_sum is kept at full width so nothing is lost before the divide.
  always_comb begin
    next_count = count + 32'd1;
    next_quot  = quot / BASE_K;
    low_digit  = DW'(quot % BASE_K);
    top_digit  = stack[IW'(sp - SPW'(1))];
    acc_sum    = {top_digit, 32'd0} + {{DW{1'b0}}, acc};
    acc_div    = acc_sum / BASE_A;
  end

  // Control FSM and all registers. The result and the valid flag are loaded
  // on the edge that enters DONE, so they are both visible during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      quot    <= '0;
      acc     <= '0;
      sp      <= '0;
      vdc_out <= '0;
      valid   <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) stack[i] <= '0;
    end else if (reseed_enable) begin
      state <= IDLE;
      count <= seed;
      quot  <= '0;
      acc   <= '0;
      sp    <= '0;
      valid <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) stack[i] <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_enable) begin
            count <= next_count;
            quot  <= next_count;
            acc   <= '0;
            sp    <= '0;
            if (next_count == 32'd0) begin
              vdc_out <= '0;
              valid   <= 1'b1;
              state   <= DONE;
            end else begin
              state <= EXTRACT;
            end
          end
        end
        EXTRACT: begin
          stack[IW'(sp)] <= low_digit;
          sp   <= sp + SPW'(1);
          quot <= next_quot;
          if (next_quot == 32'd0) state <= ACCUM;
        end
        ACCUM: begin
          acc <= 32'(acc_div);
          sp  <= sp - SPW'(1);
          if (sp == SPW'(1)) begin
            vdc_out <= 32'(acc_div);
            valid   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_vdc_32bit.sv
// tb_vdc_32bit: directed and randomized checks of vdc_32bit for radices 2, 3, 5 and 7.
// Four instances share clock and reset; each has its own pop/reseed/seed lines.
module tb_vdc_32bit;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0]       pop;
  logic [3:0]       reseed;
  logic [3:0]       valid;
  logic [3:0]       busy;
  logic [3:0][31:0] seed;
  logic [3:0][31:0] vdc;

  int total = 0;
  int bad = 0;
  int bases [4] = '{2, 3, 5, 7};
  logic [31:0] mcount [4];

  typedef struct {
    int          unit;
    logic [31:0] seed;
    logic [31:0] expect_val;
    int          expect_lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  vdc_32bit #(.BASE(2)) u_b2 (.clk(clk), .rst_n(rst_n), .pop_enable(pop[0]), .seed(seed[0]),
    .reseed_enable(reseed[0]), .vdc_out(vdc[0]), .valid(valid[0]), .busy(busy[0]));
  vdc_32bit #(.BASE(3)) u_b3 (.clk(clk), .rst_n(rst_n), .pop_enable(pop[1]), .seed(seed[1]),
    .reseed_enable(reseed[1]), .vdc_out(vdc[1]), .valid(valid[1]), .busy(busy[1]));
  vdc_32bit #(.BASE(5)) u_b5 (.clk(clk), .rst_n(rst_n), .pop_enable(pop[2]), .seed(seed[2]),
    .reseed_enable(reseed[2]), .vdc_out(vdc[2]), .valid(valid[2]), .busy(busy[2]));
  vdc_32bit #(.BASE(7)) u_b7 (.clk(clk), .rst_n(rst_n), .pop_enable(pop[3]), .seed(seed[3]),
    .reseed_enable(reseed[3]), .vdc_out(vdc[3]), .valid(valid[3]), .busy(busy[3]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int u, input logic [31:0] s);
    seed[u]   = s;
    reseed[u] = 1'b1;
    tick;
    reseed[u] = 1'b0;
    mcount[u] = s;
  endtask

  // One-cycle pop, then count edges until valid; lat=1 means valid right after the pop edge.
  task automatic popAndWait(input int u, output logic [31:0] val, output int lat);
    pop[u] = 1'b1;
    tick;
    pop[u] = 1'b0;
    mcount[u] = mcount[u] + 32'd1;
    lat = 1;
    while (valid[u] !== 1'b1 && lat < 200) begin
      tick;
      lat++;
    end
    val = vdc[u];
    tick;
  endtask

  // Exact reference: digit-reversed integer over b^n, scaled by 2^32 and floored.
  function automatic logic [31:0] model_vdc(input int b, input logic [31:0] k);
    logic [127:0] num, den, kk, bb;
    num = '0;
    den = 128'd1;
    kk  = 128'(k);
    bb  = 128'(b);
    while (kk != 0) begin
      num = num * bb + kk % bb;
      den = den * bb;
      kk  = kk / bb;
    end
    return 32'((num << 32) / den);
  endfunction

  // Runaway guard: report and stop if the sequence never completes.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, total=%0d", total);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    logic [31:0] got;
    logic [31:0] results [4];
    int lat;
    int nvals;
    int cyc;
    int first_lat;
    bit saw;

    vecs[0]  = '{0, 32'h0000_0000, 32'h8000_0000, 3};
    vecs[1]  = '{0, 32'h0000_0002, 32'hC000_0000, 5};
    vecs[2]  = '{0, 32'h0000_0005, 32'h6000_0000, 7};
    vecs[3]  = '{0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 65};
    vecs[4]  = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[5]  = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 65};
    vecs[6]  = '{1, 32'h0000_0000, 32'h5555_5555, 3};
    vecs[7]  = '{1, 32'h0000_0001, 32'hAAAA_AAAA, 3};
    vecs[8]  = '{1, 32'h0000_0002, 32'h1C71_C71C, 5};
    vecs[9]  = '{1, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[10] = '{2, 32'h0000_0000, 32'h3333_3333, 3};
    vecs[11] = '{2, 32'h0000_0006, 32'h70A3_D70A, 5};
    vecs[12] = '{3, 32'h0000_0000, 32'h2492_4924, 3};
    vecs[13] = '{3, 32'h0000_0007, 32'h29CB_C14E, 5};

    // Reset held while pop and reseed are also asserted: reset must win.
    rst_n  = 1'b0;
    pop    = 4'hF;
    reseed = 4'hF;
    for (int u = 0; u < 4; u++) seed[u] = 32'hDEAD_BEEF;
    tick;
    tick;
    for (int u = 0; u < 4; u++) begin
      checkOutput($sformatf("reset_vdc_u%0d", u), vdc[u], 32'h0);
      checkOutput($sformatf("reset_valid_u%0d", u), 32'(valid[u]), 32'h0);
      checkOutput($sformatf("reset_busy_u%0d", u), 32'(busy[u]), 32'h0);
      mcount[u] = 32'h0;
    end
    pop    = 4'h0;
    reseed = 4'h0;

    // Release reset with pop held high on the radix-2 unit: back-to-back results.
    rst_n  = 1'b1;
    pop[0] = 1'b1;
    nvals = 0;
    cyc = 0;
    first_lat = 0;
    while (nvals < 4 && cyc < 200) begin
      tick;
      cyc++;
      if (valid[0] === 1'b1) begin
        results[nvals] = vdc[0];
        if (nvals == 0) first_lat = cyc;
        nvals++;
      end
    end
    pop[0] = 1'b0;
    tick;
    checkOutput("stream_count", 32'(nvals), 32'd4);
    checkOutput("stream_first_latency", 32'(first_lat), 32'd3);
    checkOutput("stream_0", results[0], 32'h8000_0000);
    checkOutput("stream_1", results[1], 32'h4000_0000);
    checkOutput("stream_2", results[2], 32'hC000_0000);
    checkOutput("stream_3", results[3], 32'h2000_0000);

    // Reseed (with pop also high) in the middle of ACCUM on a 32-digit value.
    applyStimulus(0, 32'hFFFF_FFFE);
    pop[0] = 1'b1;
    tick;
    pop[0] = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      tick;
      if (valid[0] === 1'b1) saw = 1'b1;
    end
    checkOutput("accum_busy", 32'(busy[0]), 32'h1);
    seed[0]   = 32'h0000_0005;
    reseed[0] = 1'b1;
    pop[0]    = 1'b1;
    tick;
    reseed[0] = 1'b0;
    pop[0]    = 1'b0;
    mcount[0] = 32'h0000_0005;
    checkOutput("abort_valid", 32'(valid[0]), 32'h0);
    checkOutput("abort_busy", 32'(busy[0]), 32'h0);
    checkOutput("abort_vdc_held", vdc[0], 32'h2000_0000);
    repeat (70) begin
      tick;
      if (valid[0] === 1'b1 || busy[0] === 1'b1) saw = 1'b1;
    end
    checkOutput("abort_no_pulse", 32'(saw), 32'h0);
    popAndWait(0, got, lat);
    checkOutput("after_reseed_value", got, 32'h6000_0000);
    checkOutput("after_reseed_latency", 32'(lat), 32'd7);

    // Reset in the middle of EXTRACT discards the work.
    applyStimulus(0, 32'h7FFF_FFFE);
    pop[0] = 1'b1;
    tick;
    pop[0] = 1'b0;
    repeat (10) tick;
    rst_n = 1'b0;
    tick;
    checkOutput("midreset_vdc", vdc[0], 32'h0);
    checkOutput("midreset_valid", 32'(valid[0]), 32'h0);
    checkOutput("midreset_busy", 32'(busy[0]), 32'h0);
    rst_n = 1'b1;
    for (int u = 0; u < 4; u++) mcount[u] = 32'h0;
    popAndWait(0, got, lat);
    checkOutput("midreset_first_value", got, 32'h8000_0000);
    checkOutput("midreset_first_latency", 32'(lat), 32'd3);

    // Directed vector table: reseed, pop once, check value and latency.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].unit, vecs[i].seed);
      popAndWait(vecs[i].unit, got, lat);
      checkOutput($sformatf("vec%0d_value", i), got, vecs[i].expect_val);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expect_lat));
    end

    // Wrap-around without an intervening reseed: 0xFFFFFFFF then 0.
    applyStimulus(0, 32'hFFFF_FFFE);
    popAndWait(0, got, lat);
    checkOutput("wrap_first_value", got, 32'hFFFF_FFFF);
    popAndWait(0, got, lat);
    checkOutput("wrap_second_value", got, 32'h0);
    checkOutput("wrap_second_latency", 32'(lat), 32'd1);

    // Randomized reseeds, gaps and pops against the reference model.
    for (int u = 0; u < 4; u++) begin
      applyStimulus(u, $urandom);
      for (int it = 0; it < 8; it++) begin
        if ($urandom_range(0, 3) == 0)
          applyStimulus(u, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 50)));
        repeat ($urandom_range(0, 3)) tick;
        popAndWait(u, got, lat);
        checkOutput($sformatf("rand_u%0d_k%08h", u, mcount[u]), got, model_vdc(bases[u], mcount[u]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
